btn_scan_ctrl: RTL

Debounce controller for the board pushbuttons. One shared sample-tick generator and a scan state machine time-multiplex a single debounce update path across `N_BTN` buttons. Each button gets a stable level plus single-cycle press, release and auto-repeat pulses. Sits between the raw button pins and the CPU I/O/control logic, and replaces the per-button debounce-plus-timer instances.

---
 rtl/btn_scan_ctrl_pkg.sv | 20 ++
 rtl/btn_scan_ctrl_if.sv | 26 ++
 rtl/btn_scan_ctrl_tick_gen.sv | 34 +++
 rtl/btn_scan_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/btn_scan_ctrl_pkg.sv
// Shared constants and scan FSM state for the pushbutton debounce controller.
package btn_pkg;

  localparam int N_BTN_DEF      = 4;
  localparam int TICK_DIV_DEF   = 100000;
  localparam int SAMPLES_DEF    = 8;
  localparam int REPEAT_DLY_DEF = 500;
  localparam int REPEAT_PER_DEF = 100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Index width that stays legal for a single-button build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_scan_ctrl_if.sv
// Button pins in, debounced level and event pulses out.
interface btn_scan_ctrl_if
  import btn_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF
);

  logic             en;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  logic             tick;

  modport master (
    output en, btn_in,
    input  btn_level, btn_press, btn_release, btn_repeat, tick
  );

  modport slave (
    input  en, btn_in,
    output btn_level, btn_press, btn_release, btn_repeat, tick
  );

endinterface

// File: rtl/btn_scan_ctrl_tick_gen.sv
// Free-running sample tick divider; parked at zero while disabled.
module tick_gen
  import btn_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Time-multiplexed debounce and auto-repeat for N_BTN pushbuttons: one button
// is serviced per cycle in the scan that follows each sample tick.
module btn_scan_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int SAMPLES    = SAMPLES_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
) (
  input logic            clk,
  input logic            rst,
  btn_scan_ctrl_if.slave bus
);

  localparam int                HOLD_W      = $clog2(REPEAT_DLY + 1);
  localparam int                IDX_W       = idx_width(N_BTN);
  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(REPEAT_DLY);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DLY - REPEAT_PER);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(N_BTN - 1);

  logic [N_BTN-1:0]   sync1_q, sync2_q;
  logic [SAMPLES-1:0] hist_q [N_BTN];
  logic [SAMPLES-1:0] hist_d [N_BTN];
  logic [HOLD_W-1:0]  hold_q [N_BTN];
  logic [HOLD_W-1:0]  hold_d [N_BTN];
  logic [N_BTN-1:0]   level_q, level_d;
  logic [N_BTN-1:0]   press_q, press_d;
  logic [N_BTN-1:0]   release_q, release_d;
  logic [N_BTN-1:0]   repeat_q, repeat_d;
  scan_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               service;
  logic               tick;
  logic [SAMPLES-1:0] hist_new;
  logic [HOLD_W-1:0]  hold_inc;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .tick(tick)
  );

  // A scan always runs to completion; en only gates the tick that starts one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    service = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        service = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    hist_new  = '0;
    hold_inc  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hist_d[i] = hist_q[i];
      hold_d[i] = hold_q[i];
      hist_new  = (hist_q[i] << 1) | SAMPLES'(sync2_q[i]);
      hold_inc  = hold_q[i] + HOLD_W'(1);
      if (service && (idx_q == IDX_W'(i))) begin
        hist_d[i] = hist_new;
        if (!level_q[i]) begin
          if (&hist_new) begin
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end
        end else if (~|hist_new) begin
          // Release wins over a repeat that would land in the same slot.
          level_d[i]   = 1'b0;
          release_d[i] = 1'b1;
          hold_d[i]    = '0;
        end else if (hold_inc == HOLD_MAX) begin
          repeat_d[i] = 1'b1;
          hold_d[i]   = HOLD_RELOAD;
        end else begin
          hold_d[i] = hold_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hist_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.btn_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      for (int i = 0; i < N_BTN; i++) begin
        hist_q[i] <= hist_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_repeat  = repeat_q;
  assign bus.tick        = tick;

endmodule
